// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held while the winner keeps requesting.
// Optional macro ARB_TIMEOUT_EN adds a hold limit of TIMEOUT cycles with a one-cycle timeout pulse.
module rr_grant_arbiter #(
  parameter int N       = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt,
  output logic             timeout
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("rr_grant_arbiter: N must be in 2..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_grant_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   win_next;
  logic               holder_req;

  // First set request bit scanning upward from ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req[(int'(ptr_q) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr_q) + k) % N);
      end
    end
  end

  assign win_next   = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
  assign holder_req = |(req & grant_q);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
`ifdef ARB_TIMEOUT_EN
        hold_d = '0;
`endif
        if (win_found) begin
          grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
          state_d = GRANT;
          ptr_d   = win_next;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      GRANT: begin
        if (!holder_req) begin
          grant_d = '0;
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // A normal release on the expiry edge takes precedence, so no pulse.
        else if (hold_q == 8'(TIMEOUT - 1)) begin
          grant_d   = '0;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == GRANT);
  assign grant_cnt = cnt_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
